// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small byte FIFO and a STATUS register.
// Define UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module mmio_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        sel,
    output logic        tx,
    output logic        busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      idx_q;
    logic [7:0]      data_q;
    logic            tx_q;
    logic            ovf_q;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW:0]     wr_ptr_q, rd_ptr_q;

    logic hit_tx, hit_st, empty, full, bit_done, pop, push, drop;
    logic [7:0] head;
    logic [2:0] idx_nxt;
    logic unused_wdata;

    assign unused_wdata = ^WriteData[31:8];

    assign hit_tx   = (DataAdr == BASE_ADDR);
    assign hit_st   = (DataAdr == BASE_ADDR + 32'd4);
    assign sel      = hit_tx | hit_st;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head     = mem_q[rd_ptr_q[AW-1:0]];
    assign bit_done = (cnt_q == CW'(CLKS_PER_BIT - 1));
    assign idx_nxt  = idx_q + 3'd1;

    // A pop in the same edge frees a slot, so a push into a full FIFO still lands.
    assign pop  = !empty && ((state_q == IDLE) || ((state_q == STOP) && bit_done));
    assign push = MemWrite && hit_tx && (!full || pop);
    assign drop = MemWrite && hit_tx && full && !pop;

    assign busy = (state_q != IDLE);
    assign tx   = tx_q;

    always_comb begin
        ReadData = '0;
        if (hit_st) ReadData = {28'b0, ovf_q, busy, full, empty};
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= WriteData[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (MemWrite && hit_st) ovf_q <= 1'b0;
            else if (drop)          ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        state_q <= START;
                        cnt_q   <= '0;
                        data_q  <= head;
                        tx_q    <= 1'b0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state_q <= DATA;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        tx_q    <= data_q[0];
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        cnt_q <= '0;
                        if (idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                            state_q <= PARITY;
                            tx_q    <= ^data_q;
`else
                            state_q <= STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            idx_q <= idx_nxt;
                            tx_q  <= data_q[idx_nxt];
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        state_q <= STOP;
                        cnt_q   <= '0;
                        tx_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        cnt_q <= '0;
                        // Chain straight into the next frame when more bytes are queued.
                        if (!empty) begin
                            state_q <= START;
                            data_q  <= head;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: stimulus queues expected frames, a tx monitor decodes and checks them.
module tb_mmio_uart_tx;
    localparam int CPB = 4;
    localparam logic [31:0] BASE = 32'h0000_0100;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int F = NB * CPB;

    typedef struct {
        logic [7:0] d;
        int         st;
        bit         b2b;
    } exp_t;

    logic        clk = 0, reset = 0, MemWrite = 0;
    logic [31:0] DataAdr = 0, WriteData = 0;
    logic [31:0] ReadData;
    logic        sel, tx, busy;

    int   checks = 0, failures = 0, cyc = 0;
    exp_t q[$];

    mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .ReadData(ReadData), .sel(sel), .tx(tx), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: decode each frame on tx, compare with the queue head
    bit         mon_busy = 0, mon_ab, mon_inc;
    int         mon_sc, last_end = -1;
    logic [10:0] mon_bits;
    exp_t       e;
    initial begin
        forever begin
            @(negedge clk);
            if (reset && tx === 1'b0) begin
                mon_busy = 1; mon_ab = 0; mon_inc = 0; mon_sc = cyc; mon_bits = '0;
                for (int b = 0; b < NB; b++) begin
                    for (int c = 0; c < CPB; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (!reset) mon_ab = 1;
                        if (c == 0) mon_bits[b] = tx;
                        else if (tx !== mon_bits[b]) mon_inc = 1;
                    end
                end
                if (!mon_ab) begin
                    if (q.size() == 0) begin
                        chk("unexpected_frame", {24'b0, mon_bits[8:1]}, 32'hFFFF_FFFF);
                    end else begin
                        e = q.pop_front();
                        chk("start_bit", {31'b0, mon_bits[0]}, 0);
                        chk("data_byte", {24'b0, mon_bits[8:1]}, {24'b0, e.d});
`ifdef UART_PARITY_EN
                        chk("parity_bit", {31'b0, mon_bits[9]}, {31'b0, ^e.d});
`endif
                        chk("stop_bit", {31'b0, mon_bits[NB-1]}, 1);
                        chk("bit_width", {31'b0, mon_inc}, 0);
                        if (e.st >= 0) chk("start_cycle", mon_sc, e.st);
                        if (e.b2b)     chk("back_to_back", mon_sc, last_end);
                    end
                    last_end = mon_sc + F;
                end
                mon_busy = 0;
            end
        end
    end

    task automatic wait_drain(input string nm);
        int i;
        for (i = 0; i < 5000; i++) begin
            if (q.size() == 0 && !busy && !mon_busy) break;
            @(negedge clk);
        end
        chk(nm, i < 5000 ? 0 : 1, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int k;
        logic [7:0] b3 [6];
        logic [7:0] b4 [6];
        b3 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        b4 = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};

        // Reset state
        idle(3);
        DataAdr = BASE + 4; #1;
        chk("rst_tx", {31'b0, tx}, 1);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_status", ReadData, 32'h1);
        chk("rst_sel", {31'b0, sel}, 1);
        @(negedge clk); reset = 1;
        idle(3);

        // Single byte 0x55: latency and frame length
        k = cyc;
        MemWrite = 1; DataAdr = BASE; WriteData = 32'hFFFF_FF55;
        q.push_back('{8'h55, k + 2, 1'b0});
        @(negedge clk); MemWrite = 0;
        chk("lat_busy_n", {31'b0, busy}, 0);
        chk("lat_tx_n", {31'b0, tx}, 1);
        @(negedge clk);
        chk("lat_busy_n1", {31'b0, busy}, 1);
        chk("lat_tx_n1", {31'b0, tx}, 0);
        while (cyc < k + 1 + F) @(negedge clk);
        chk("busy_last", {31'b0, busy}, 1);
        @(negedge clk);
        chk("busy_drop", {31'b0, busy}, 0);
        wait_drain("drain_55");
        idle(5);

        // Six pushes from idle: 5 stored, 1 dropped
        k = cyc;
        for (int i = 0; i < 6; i++) begin
            MemWrite = 1; DataAdr = BASE; WriteData = {24'b0, b3[i]};
            if (i < 5) q.push_back('{b3[i], i == 0 ? k + 2 : -1, i != 0});
            @(negedge clk);
        end
        MemWrite = 0; DataAdr = BASE + 4; #1;
        chk("ovf_status", ReadData, 32'hE);
        MemWrite = 1; WriteData = 0;
        @(negedge clk); MemWrite = 0; #1;
        chk("ovf_clear", ReadData, 32'h6);
        DataAdr = BASE + 8; #1;
        chk("oow_sel", {31'b0, sel}, 0);
        chk("oow_rdata", ReadData, 0);
        DataAdr = BASE; #1;
        chk("txdata_sel", {31'b0, sel}, 1);
        chk("txdata_rdata", ReadData, 0);
        wait_drain("drain_ovf");
        idle(5);

        // Full FIFO, push coinciding with the pop at end of STOP
        k = cyc;
        for (int i = 0; i < 5; i++) begin
            MemWrite = 1; DataAdr = BASE; WriteData = {24'b0, b4[i]};
            q.push_back('{b4[i], i == 0 ? k + 2 : -1, i != 0});
            @(negedge clk);
        end
        MemWrite = 0; DataAdr = BASE + 4;
        while (cyc < k + 1 + F) @(negedge clk);
        #1 chk("full_pre", ReadData, 32'h6);
        MemWrite = 1; DataAdr = BASE; WriteData = {24'b0, b4[5]};
        q.push_back('{b4[5], -1, 1'b1});
        @(negedge clk);
        MemWrite = 0; DataAdr = BASE + 4; #1;
        chk("full_coincide", ReadData, 32'h6);
        wait_drain("drain_full");
        idle(5);

        // Reset mid-frame during DATA bit 3
        k = cyc;
        MemWrite = 1; DataAdr = BASE; WriteData = 32'hA5;
        @(negedge clk); MemWrite = 0;
        while (cyc < k + 3 + 4 * CPB) @(negedge clk);
        chk("pre_rst_bit3", {31'b0, tx}, 0);
        #2 reset = 0; DataAdr = BASE + 4; #1;
        chk("midrst_tx", {31'b0, tx}, 1);
        chk("midrst_busy", {31'b0, busy}, 0);
        chk("midrst_status", ReadData, 32'h1);
        @(negedge clk); #2 reset = 1;
        idle(3 * F);
        chk("post_rst_tx", {31'b0, tx}, 1);
        chk("post_rst_busy", {31'b0, busy}, 0);
        k = cyc;
        MemWrite = 1; DataAdr = BASE; WriteData = 32'h3C;
        q.push_back('{8'h3C, k + 2, 1'b0});
        @(negedge clk); MemWrite = 0;
        wait_drain("drain_post_rst");
        chk("queue_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the single-cycle core's data bus, alongside the data memory. It decodes the core's store/load address, queues written bytes in a small FIFO and serialises them 8N1 on `tx`. It returns a status word for loads to its address window. The top level muxes `ReadData` between data memory and this block using `sel`.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; must be ≥ 2.
- `FIFO_DEPTH`, 4: FIFO entries; must be a power of 2, ≥ 2.
- `BASE_ADDR`, 32'h0000_0100: word-aligned base address of the 2-word register window.
- `clk`  in  1  core clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `MemWrite`  in  1  core store strobe.
- `DataAdr`  in  32  core data address (ALU result).
- `WriteData`  in  32  core store data.
- `ReadData`  out  32  status word; combinational from `DataAdr`.
- `sel`  out  1  combinational; `DataAdr` is `BASE_ADDR` or `BASE_ADDR+4`.
- `tx`  out  1  serial output; idle high.
- `busy`  out  1  transmitter FSM not in IDLE.

## Operation
- Register map:
  - `BASE+0` TXDATA, write-only: push `WriteData[7:0]`.
  - `BASE+4` STATUS: read returns `{28'b0, overflow, busy, full, empty}`. Any write clears `overflow`.
- `ReadData` is 0 when `DataAdr` is outside the window, including on reads of `BASE+0`.
- Push: at a rising edge with `MemWrite=1` and `DataAdr==BASE+0`.
  - If the FIFO is not full, the byte is stored.
  - If full, the byte is dropped and `overflow` is set (sticky).
- FIFO: circular buffer; pointers one bit wider than log2(`FIFO_DEPTH`); `empty`/`full` derive from the pointers.
- FSM states: IDLE → START → DATA(8 bits, LSB first) → [PARITY] → STOP.
  - `tx` is 1 in IDLE and STOP, 0 in START, and the data bit in DATA.
  - Each state other than IDLE holds `tx` for exactly `CLKS_PER_BIT` cycles via a bit counter (0..CLKS_PER_BIT-1) and a bit index (0..7).
- IDLE → START at an edge where the FIFO is non-empty. That same edge pops the head into the shift register.
- End of STOP:
  - FIFO non-empty: pop and go directly to START (no idle gap).
  - Otherwise go to IDLE.
- Simultaneous push and pop:
  - Full: push accepted, count unchanged, no overflow.
  - Empty: the push lands, and the pop occurs at the next edge.
- Reset (async assert, any state including mid-frame):
  - `tx`=1, state IDLE, FIFO empty, `overflow`=0, counters 0.
  - A frame in flight is abandoned; no partial completion.
  - Release is synchronous to the next rising edge.

## Timing
- Reset values: `tx`=1, `busy`=0, `ReadData`=0 unless `DataAdr` hits STATUS (then 32'h1), `sel` combinational.
- Latency, from an idle, empty state: push at edge N, pop and START at edge N+1. `tx` falls after edge N+1 and `busy`=1 after edge N+1.
- Frame length: 10×`CLKS_PER_BIT` cycles (11× with parity).
- Back-to-back frames: the next START begins the cycle after the last STOP cycle.
- STATUS flags reflect register state after the last edge, with no extra delay.

## Configuration
- `UART_PARITY_EN`:
  - Defined: a PARITY state between DATA and STOP transmits the even-parity bit (XOR of the 8 data bits) for `CLKS_PER_BIT` cycles.
  - Undefined: DATA goes directly to STOP.
- The register map and all other timing are identical in both builds.

## Test plan
- Reset mid-frame: pulse `reset` low during DATA bit 3 → `tx`=1 and `busy`=0 immediately; STATUS reads 32'h1.
- `CLKS_PER_BIT`=4, push 0x55 → `tx` low from edge N+1 for 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles; `busy` drops after 40 cycles.
- `FIFO_DEPTH`=4, push 6 bytes on consecutive cycles starting idle → the first pops at the next edge, so 5 are stored and 1 is dropped. STATUS `overflow`=1 and `full`=1; output is 5 back-to-back frames with no idle gap.
- Overflow clear: with `overflow` set, write 0 to `BASE+4` → STATUS bit3=0 next cycle. Then load `BASE+8` → `sel`=0 and `ReadData`=0.
- Full FIFO with a push coinciding with the pop at end of STOP → no overflow; all bytes transmitted in order.
- `UART_PARITY_EN` defined, push 0x07 → parity bit 1; frame 44 cycles at `CLKS_PER_BIT`=4.
